// File: rtl/mat_host_sequencer_if.sv
// rtl/mat_host_sequencer_if.sv - job control, operand/result streams and controller command bus
interface mat_host_sequencer_if #(
    parameter int DW = 16
);
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA;
    logic          CTRL_EN;
    logic          CTRL_WRITE;
    logic          CTRL_LOAD;
    logic [2:0]    CTRL_IDX;
    logic [3:0]    CTRL_REG_SELECT;
    logic [DW-1:0] CTRL_DATA_IN;
    logic [DW-1:0] CTRL_DATA_OUT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_LAST;

    modport master (
        input  START, IN_VALID, IN_DATA, CTRL_DATA_OUT, OUT_READY,
        output BUSY, DONE, IN_READY, CTRL_EN, CTRL_WRITE, CTRL_LOAD, CTRL_IDX,
               CTRL_REG_SELECT, CTRL_DATA_IN, OUT_VALID, OUT_DATA, OUT_LAST
    );

    modport slave (
        output START, IN_VALID, IN_DATA, CTRL_DATA_OUT, OUT_READY,
        input  BUSY, DONE, IN_READY, CTRL_EN, CTRL_WRITE, CTRL_LOAD, CTRL_IDX,
               CTRL_REG_SELECT, CTRL_DATA_IN, OUT_VALID, OUT_DATA, OUT_LAST
    );
endinterface

// File: rtl/mat_host_sequencer.sv
// rtl/mat_host_sequencer.sv - streams 128 operands into the 8x8 array, loads, computes, reads back 64 results
module mat_host_sequencer #(
    parameter int DW             = 16,
    parameter int COMPUTE_CYCLES = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    mat_host_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR, LOAD, COMP, RD_ISSUE, RD_WAIT, RD_OUT, FIN
    } state_t;

    localparam logic [7:0] CC_LAST = 8'(COMPUTE_CYCLES - 1);

    state_t        state, state_nx;
    logic [6:0]    k, k_nx;
    logic [3:0]    lcnt, lcnt_nx;
    logic [7:0]    ccnt, ccnt_nx;
    logic [5:0]    j, j_nx, j_inc;
    logic          en_r, wr_r, ld_r, en_nx, wr_nx, ld_nx;
    logic [2:0]    idx_r, idx_nx;
    logic [3:0]    rs_r, rs_nx;
    logic [DW-1:0] din_r, din_nx;
    logic [DW-1:0] out_data_r;
    logic          out_last_r;
    logic          in_hs;

    assign in_hs = (state == WR) && bus.IN_VALID;
    assign j_inc = j + 6'd1;

    // The *_nx command is what the controller sees next cycle; every CTRL_* pin is a flop.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        lcnt_nx  = lcnt;
        ccnt_nx  = ccnt;
        j_nx     = j;
        en_nx    = 1'b0;
        wr_nx    = 1'b0;
        ld_nx    = 1'b0;
        idx_nx   = 3'd0;
        rs_nx    = 4'd0;
        din_nx   = '0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nx = WR;
                    k_nx     = 7'd0;
                    lcnt_nx  = 4'd0;
                    ccnt_nx  = 8'd0;
                    j_nx     = 6'd0;
                end
            end
            WR: begin
                if (in_hs) begin
                    en_nx  = 1'b1;
                    wr_nx  = 1'b1;
                    rs_nx  = k[6:3];
                    idx_nx = k[2:0];
                    din_nx = bus.IN_DATA;
                    if (k == 7'd127) begin
                        state_nx = LOAD;
                    end else begin
                        k_nx = k + 7'd1;
                    end
                end
            end
            // First LOAD cycle still shows the last write on the pins, hence 9 cycles for 8 loads.
            LOAD: begin
                en_nx = 1'b1;
                if (lcnt == 4'd8) begin
                    state_nx = COMP;
                end else begin
                    ld_nx   = 1'b1;
                    lcnt_nx = lcnt + 4'd1;
                end
            end
            COMP: begin
                en_nx = 1'b1;
                if (ccnt == CC_LAST) begin
                    state_nx = RD_ISSUE;
                    wr_nx    = 1'b1;
                    ld_nx    = 1'b1;
                    rs_nx    = {1'b0, j[5:3]};
                    idx_nx   = j[2:0];
                end else begin
                    ccnt_nx = ccnt + 8'd1;
                end
            end
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  state_nx = RD_OUT;
            RD_OUT: begin
                if (bus.OUT_READY) begin
                    if (j == 6'd63) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = RD_ISSUE;
                        j_nx     = j_inc;
                        en_nx    = 1'b1;
                        wr_nx    = 1'b1;
                        ld_nx    = 1'b1;
                        rs_nx    = {1'b0, j_inc[5:3]};
                        idx_nx   = j_inc[2:0];
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            k          <= 7'd0;
            lcnt       <= 4'd0;
            ccnt       <= 8'd0;
            j          <= 6'd0;
            en_r       <= 1'b0;
            wr_r       <= 1'b0;
            ld_r       <= 1'b0;
            idx_r      <= 3'd0;
            rs_r       <= 4'd0;
            din_r      <= '0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            lcnt  <= lcnt_nx;
            ccnt  <= ccnt_nx;
            j     <= j_nx;
            en_r  <= en_nx;
            wr_r  <= wr_nx;
            ld_r  <= ld_nx;
            idx_r <= idx_nx;
            rs_r  <= rs_nx;
            din_r <= din_nx;
            if (state == RD_WAIT) begin
                out_data_r <= bus.CTRL_DATA_OUT;
                out_last_r <= (j == 6'd63);
            end
        end
    end

    assign bus.BUSY            = (state != IDLE) && (state != FIN);
    assign bus.DONE            = (state == FIN);
    assign bus.IN_READY        = (state == WR);
    assign bus.OUT_VALID       = (state == RD_OUT);
    assign bus.OUT_DATA        = out_data_r;
    assign bus.OUT_LAST        = out_last_r;
    assign bus.CTRL_EN         = en_r;
    assign bus.CTRL_WRITE      = wr_r;
    assign bus.CTRL_LOAD       = ld_r;
    assign bus.CTRL_IDX        = idx_r;
    assign bus.CTRL_REG_SELECT = rs_r;
    assign bus.CTRL_DATA_IN    = din_r;
endmodule

// File: tb/tb_mat_host_sequencer.sv
// tb/tb_mat_host_sequencer.sv - directed self-checking bench for mat_host_sequencer
module tb_mat_host_sequencer;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mat_host_sequencer_if #(.DW(16)) bus ();

    mat_host_sequencer #(.DW(16), .COMPUTE_CYCLES(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Controller read path: registered data, 16'h1000 + result index
    always @(posedge CLK) begin
        if (bus.CTRL_EN && bus.CTRL_LOAD && bus.CTRL_WRITE)
            bus.CTRL_DATA_OUT <= 16'h1000 + {10'd0, bus.CTRL_REG_SELECT[2:0], bus.CTRL_IDX};
    end

    typedef struct packed {
        logic        rdy;
        logic        en;
        logic        wr;
        logic        ld;
        logic [3:0]  rs;
        logic [2:0]  idx;
        logic [15:0] din;
    } cmd_t;

    cmd_t log_q[$];
    bit   mon_en = 1'b0;

    always @(negedge CLK) begin
        if (mon_en)
            log_q.push_back('{bus.IN_READY, bus.CTRL_EN, bus.CTRL_WRITE, bus.CTRL_LOAD,
                              bus.CTRL_REG_SELECT, bus.CTRL_IDX, bus.CTRL_DATA_IN});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {17'd0, bus.BUSY, bus.DONE, bus.IN_READY, bus.OUT_VALID, bus.OUT_LAST,
                bus.OUT_DATA, bus.CTRL_EN, bus.CTRL_WRITE, bus.CTRL_LOAD, bus.CTRL_IDX,
                bus.CTRL_REG_SELECT, bus.CTRL_DATA_IN};
    endfunction

    function automatic logic [63:0] pins();
        return {37'd0, bus.CTRL_EN, bus.CTRL_WRITE, bus.CTRL_LOAD,
                bus.CTRL_REG_SELECT, bus.CTRL_IDX, bus.CTRL_DATA_IN};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one word and return #1 after the edge on which it was accepted
    task automatic push(input logic [15:0] d, inout int timeouts);
        bit seen = 1'b0;
        bus.IN_DATA  = d;
        bus.IN_VALID = 1'b1;
        for (int w = 0; w < 50 && !seen; w++) begin
            @(negedge CLK);
            seen = bus.IN_READY;
        end
        if (seen) step();
        else timeouts++;
    endtask

    task automatic start_job();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    task automatic analyze(input logic [15:0] base, output int wcnt, output int seqbad,
                           output int badcombo, output int gapzero, output int iw);
        int first = -1;
        wcnt = 0; seqbad = 0; badcombo = 0; gapzero = 0; iw = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].rdy && log_q[i].en && !log_q[i].wr && !log_q[i].ld) badcombo++;
            if (log_q[i].en && log_q[i].wr && !log_q[i].ld) begin
                if (first < 0) first = i;
                if (log_q[i].rs != wcnt[6:3] || log_q[i].idx != wcnt[2:0] ||
                    log_q[i].din != base + wcnt[15:0]) seqbad++;
                iw = i;
                wcnt++;
            end
        end
        if (first >= 0)
            for (int i = first; i <= iw; i++)
                if (!log_q[i].en) gapzero++;
    endtask

    task automatic readback(input bit toggle, output int n, output int mism, output int lastbad,
                            output int stallbad, output int stalls, output int donebad);
        bit            stalled = 1'b0;
        bit            got_all = 1'b0;
        logic [15:0]   held = '0;
        n = 0; mism = 0; lastbad = 0; stallbad = 0; stalls = 0; donebad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            if (got_all) begin
                if (!(bus.DONE === 1'b1 && bus.BUSY === 1'b0)) donebad++;
                break;
            end
            if (bus.OUT_VALID) begin
                if (stalled && bus.OUT_DATA !== held) stallbad++;
                if (bus.OUT_READY) begin
                    if (bus.OUT_DATA !== 16'h1000 + 16'(n)) mism++;
                    if (bus.OUT_LAST !== (n == 63)) lastbad++;
                    if (bus.DONE !== 1'b0) donebad++;
                    n++;
                    stalled = 1'b0;
                    if (n == 64) got_all = 1'b1;
                end else begin
                    stalled = 1'b1;
                    held    = bus.OUT_DATA;
                    stalls++;
                end
            end
            step();
            if (toggle) bus.OUT_READY = ~bus.OUT_READY;
        end
    endtask

    initial begin
        int to_cnt, wcnt, seqbad, badcombo, gapzero, iw, cnt, idx;
        int n, mism, lastbad, stallbad, stalls, donebad;
        logic [63:0] rd_cmd;

        bus.START = 1'b0; bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
        bus.OUT_READY = 1'b0; bus.CTRL_DATA_OUT = '0;
        to_cnt = 0;

        // Reset held: stimulus must not move anything
        for (int i = 0; i < 4; i++) begin
            bus.START    = ~bus.START;
            bus.IN_VALID = ~bus.IN_VALID;
            @(negedge CLK);
            chk("reset_outputs", outs(), 64'd0);
        end
        bus.START = 1'b0; bus.IN_VALID = 1'b0;
        step();
        RST = 1'b1;
        step(); step();
        chk("post_reset_idle", outs(), 64'd0);

        // Job 1: continuous stream, START during COMP, readback with toggling OUT_READY
        log_q.delete();
        mon_en = 1'b1;
        start_job();
        chk("busy_after_start", bus.BUSY, 1'b1);
        for (int k = 0; k < 128; k++) begin
            push(16'(k), to_cnt);
            if (k == 75)
                chk("word75_cmd", pins(), {37'd0, 3'b110, 4'd9, 3'd3, 16'd75});
        end
        bus.IN_VALID = 1'b0;
        chk("in_ready_low_after_127", bus.IN_READY, 1'b0);
        chk("job1_push_timeouts", to_cnt, 0);
        repeat (11) step();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        chk("busy_in_comp", bus.BUSY, 1'b1);
        bus.OUT_READY = 1'b1;
        readback(1'b1, n, mism, lastbad, stallbad, stalls, donebad);
        chk("rb1_count", n, 64);
        chk("rb1_data", mism, 0);
        chk("rb1_last", lastbad, 0);
        chk("rb1_stable_stall", stallbad, 0);
        chk("rb1_stall_seen", (stalls > 0), 1'b1);
        chk("rb1_done", donebad, 0);
        step();
        chk("done_one_cycle", {bus.DONE, bus.BUSY}, 2'b00);
        mon_en = 1'b0;

        analyze(16'd0, wcnt, seqbad, badcombo, gapzero, iw);
        chk("job1_writes", wcnt, 128);
        chk("job1_write_seq", seqbad, 0);
        chk("job1_no_enable_only", badcombo, 0);
        chk("job1_no_gaps", gapzero, 0);
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            idx = iw + i;
            if (idx < log_q.size() && log_q[idx].en && log_q[idx].ld && !log_q[idx].wr) cnt++;
        end
        chk("load_cycles", cnt, 8);
        cnt = 0;
        for (int i = 9; i <= 13; i++) begin
            idx = iw + i;
            if (idx < log_q.size() && log_q[idx].en && !log_q[idx].ld && !log_q[idx].wr) cnt++;
        end
        chk("compute_cycles", cnt, 5);
        rd_cmd = 64'd0;
        if (iw + 14 < log_q.size())
            rd_cmd = {54'd0, log_q[iw+14].en, log_q[iw+14].wr, log_q[iw+14].ld,
                      log_q[iw+14].rs, log_q[iw+14].idx};
        chk("first_read_cmd", rd_cmd, {54'd0, 3'b111, 4'd0, 3'd0});

        // Job 2: input gaps 1,0,0,1 and free-flowing output
        log_q.delete();
        mon_en = 1'b1;
        start_job();
        for (int k = 0; k < 128; k++) begin
            push(16'h2000 + 16'(k), to_cnt);
            if (k % 2 == 0) begin
                bus.IN_VALID = 1'b0;
                step(); step();
            end
        end
        bus.IN_VALID = 1'b0;
        chk("job2_push_timeouts", to_cnt, 0);
        bus.OUT_READY = 1'b1;
        readback(1'b0, n, mism, lastbad, stallbad, stalls, donebad);
        mon_en = 1'b0;
        chk("rb2_count", n, 64);
        chk("rb2_data", mism, 0);
        chk("rb2_last_done", lastbad + donebad, 0);
        analyze(16'h2000, wcnt, seqbad, badcombo, gapzero, iw);
        chk("job2_writes", wcnt, 128);
        chk("job2_write_seq", seqbad, 0);
        chk("job2_no_enable_only", badcombo, 0);
        chk("job2_gap_cycles_idle", gapzero, 128);

        // Job 3: async reset mid-write, then restart from word 0
        step();
        start_job();
        for (int k = 0; k < 10; k++) push(16'h3000 + 16'(k), to_cnt);
        bus.IN_VALID = 1'b0;
        chk("midwr_cmd_present", pins(), {37'd0, 3'b110, 4'd1, 3'd1, 16'h3009});
        #2;
        RST = 1'b0;
        #1;
        chk("midwr_reset_outputs", outs(), 64'd0);
        #2;
        RST = 1'b1;
        step();
        start_job();
        push(16'h0ABC, to_cnt);
        bus.IN_VALID = 1'b0;
        chk("restart_k0_cmd", pins(), {37'd0, 3'b110, 4'd0, 3'd0, 16'h0ABC});
        chk("job3_push_timeouts", to_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
